led_panel_sink: RTL



---
 rtl/led_panel_sink.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/led_panel_sink.sv
// Panel-side receiver for the single-chain LED interface: rebuilds the latched line,
// tracks the row address and flags protocol errors seen on the wire.
module led_panel_sink #(
   parameter int COLS    = 64,
   parameter int ROWBITS = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               red_in,
   input  logic               green_in,
   input  logic               blue_in,
   input  logic               sclk_in,
   input  logic               latch_in,
   input  logic               blank_in,
   input  logic               aclk_in,
   input  logic               arst_in,
   input  logic [6:0]         pix_addr_in,
   output logic [2:0]         pix_rgb_out,
   output logic [ROWBITS-1:0] row_out,
   output logic [ROWBITS-1:0] line_row_out,
   output logic [7:0]         cols_out,
   output logic               line_valid_out,
   output logic               frame_out,
   output logic               lit_out,
   output logic               err_overflow_out,
   output logic               err_unblanked_out
);

   // s1 layout: {red, green, blue, sclk, latch, blank, aclk, arst}
   localparam int B_SCLK  = 4;
   localparam int B_LATCH = 3;
   localparam int B_BLANK = 2;
   localparam int B_ACLK  = 1;
   localparam int B_ARST  = 0;

   logic [7:0]         s1_reg;
   logic [3:0]         s2_reg;   // only the strobes need a second stage for edge detection
   logic               sclk_rise;
   logic               latch_fall;
   logic               aclk_rise;
   logic               arst_rise;
   logic [7:0]         cnt_reg;
   logic [7:0]         cnt_next;
   logic [ROWBITS-1:0] row_reg;
   logic               addr_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= {red_in, green_in, blue_in, sclk_in, latch_in, blank_in, aclk_in, arst_in};
         s2_reg <= {s1_reg[B_SCLK], s1_reg[B_LATCH], s1_reg[B_ACLK], s1_reg[B_ARST]};
      end
   end

   assign sclk_rise  =  s1_reg[B_SCLK]  & ~s2_reg[3];
   assign latch_fall = ~s1_reg[B_LATCH] &  s2_reg[2];
   assign aclk_rise  =  s1_reg[B_ACLK]  & ~s2_reg[1];
   assign arst_rise  =  s1_reg[B_ARST]  & ~s2_reg[0];

   always_comb begin
      cnt_next = cnt_reg;
      if (sclk_rise && cnt_reg != 8'hFF)
         cnt_next = cnt_reg + 8'd1;
   end

   assign addr_ok = ({1'b0, pix_addr_in} < 8'(COLS));

   // One shift/display register pair per colour; gi=0 is red, 2 is blue.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_colour
         logic [COLS-1:0] sr_reg;
         logic [COLS-1:0] sr_next;
         logic [COLS-1:0] disp_reg;
         logic [127:0]    disp_ext;

         always_comb begin
            sr_next = sr_reg;
            if (sclk_rise)
               sr_next = {sr_reg[COLS-2:0], s1_reg[7-gi]};
         end

         // Latch takes sr_next so a shift in the same cycle lands in the line.
         always_ff @(posedge clk) begin
            if (reset) begin
               sr_reg   <= '0;
               disp_reg <= '0;
            end else begin
               sr_reg <= sr_next;
               if (latch_fall)
                  disp_reg <= sr_next;
            end
         end

         assign disp_ext           = 128'(disp_reg);
         assign pix_rgb_out[2-gi]  = addr_ok & disp_ext[pix_addr_in];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg           <= '0;
         cols_out          <= '0;
         line_row_out      <= '0;
         line_valid_out    <= 1'b0;
         frame_out         <= 1'b0;
         lit_out           <= 1'b0;
         err_overflow_out  <= 1'b0;
         err_unblanked_out <= 1'b0;
         row_reg           <= '0;
      end else begin
         line_valid_out <= latch_fall;
         frame_out      <= arst_rise;
         lit_out        <= ~s1_reg[B_BLANK];

         if (latch_fall) begin
            cols_out     <= cnt_next;
            cnt_reg      <= '0;
            line_row_out <= row_reg;
            if (!s1_reg[B_BLANK])
               err_unblanked_out <= 1'b1;
         end else begin
            cnt_reg <= cnt_next;
         end

         if (int'(cnt_next) > COLS)
            err_overflow_out <= 1'b1;

         if (s1_reg[B_ARST])
            row_reg <= '0;
         else if (aclk_rise)
            row_reg <= row_reg + ROWBITS'(1);
      end
   end

   assign row_out = row_reg;

endmodule
